// File: rtl/rf_write_scheduler_if.sv
// Writeback, operand-read and register-file port bundle for rf_write_scheduler.
// master = datapath/register-file side, slave = the scheduler.
interface rf_write_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              wr_valid;
    logic              wr_ready;
    logic [1:0]        wr_dst;
    logic [4:0]        wr_reg;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic [4:0]        rd_rs;
    logic [4:0]        rd_rt;
    logic              rd_grant;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    logic [4:0]        rf_rs;
    logic [4:0]        rf_rt;
    logic [1:0]        rf_RegDst;
    logic              rf_RegWrite;
    logic [DATA_W-1:0] rf_WriteData;
    logic [DATA_W-1:0] rf_readData1;
    logic [DATA_W-1:0] rf_readData2;

    logic [2:0]        wb_count;

    modport master (
        output wr_valid, wr_dst, wr_reg, wr_data,
        output rd_valid, rd_rs, rd_rt,
        output rf_readData1, rf_readData2,
        input  wr_ready, rd_grant, rd_data1, rd_data2,
        input  rf_rs, rf_rt, rf_RegDst, rf_RegWrite, rf_WriteData,
        input  wb_count
    );

    modport slave (
        input  wr_valid, wr_dst, wr_reg, wr_data,
        input  rd_valid, rd_rs, rd_rt,
        input  rf_readData1, rf_readData2,
        output wr_ready, rd_grant, rd_data1, rd_data2,
        output rf_rs, rf_rt, rf_RegDst, rf_RegWrite, rf_WriteData,
        output wb_count
    );
endinterface

// File: rtl/rf_write_scheduler.sv
// Buffers writebacks in a DEPTH-entry FIFO and drains one per cycle into the register file write port.
// Reads own the port when hazard-free; a request into an empty FIFO commits one edge after accept; wr_ready drops when full.
module rf_write_scheduler #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    rf_write_scheduler_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]        idx;
        logic [DATA_W-1:0] dat;
    } wb_entry_t;

    wb_entry_t          mem [DEPTH];
    logic [DEPTH-1:0]   ent_vld;
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [2:0]         count;

    logic [4:0]         push_idx;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               haz_rs;
    logic               haz_rt;
    logic               haz;
    logic               read_win;
    wb_entry_t          head_ent;

    assign fifo_empty   = (count == 3'd0);
    assign bus.wr_ready = (count < 3'(DEPTH));
    assign bus.wb_count = count;
    assign head_ent     = mem[head];

    // $ra writes ignore wr_reg; dst 11 and $zero are accepted but never stored
    assign push_idx = (bus.wr_dst == 2'b10) ? 5'd31 : bus.wr_reg;
    assign push     = !rst && bus.wr_valid && bus.wr_ready
                      && (bus.wr_dst != 2'b11) && (push_idx != 5'd0);

    always_comb begin
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[PW'(i)]) begin
                if (mem[PW'(i)].idx == bus.rd_rs) haz_rs = 1'b1;
                if (mem[PW'(i)].idx == bus.rd_rt) haz_rt = 1'b1;
            end
        end
        if (push && (push_idx == bus.rd_rs)) haz_rs = 1'b1;
        if (push && (push_idx == bus.rd_rt)) haz_rt = 1'b1;
    end

    assign haz      = bus.rd_valid && (((bus.rd_rs != 5'd0) && haz_rs)
                                    || ((bus.rd_rt != 5'd0) && haz_rt));
    assign read_win = bus.rd_valid && !haz;
    // Reset blocks the drain so entries pending at reset never reach the register file
    assign pop      = !rst && !read_win && !fifo_empty;

    always_comb begin
        bus.rd_grant     = read_win;
        bus.rf_RegWrite  = pop;
        bus.rf_rs        = bus.rd_rs;
        bus.rf_rt        = bus.rd_rt;
        bus.rf_WriteData = head_ent.dat;
        if (pop) begin
            bus.rf_rs = head_ent.idx;
            bus.rf_rt = 5'd0;
        end
    end

    assign bus.rf_RegDst = 2'b00;
    assign bus.rd_data1  = bus.rf_readData1;
    assign bus.rd_data2  = bus.rf_readData2;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{idx: push_idx, dat: bus.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= 3'd0;
            ent_vld <= '0;
        end else begin
            // push and pop never share a slot: push needs count < DEPTH, pop needs count > 0
            if (push) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            count <= count + 3'(push) - 3'(pop);
        end
    end
endmodule
